// File: rtl/lookahead_adder.sv
// lookahead_adder: 16-bit two-level carry-lookahead adder with registered sum/carry-out.
// Define LOOKAHEAD_OVF_EN to add the registered signed-overflow output ovf.
module lookahead_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] operand1,
    input  logic [15:0] operand2,
    input  logic        cin,
    output logic        cout,
    output logic [15:0] result
`ifdef LOOKAHEAD_OVF_EN
    ,
    output logic        ovf
`endif
);
    logic [15:0] p, g, c, s;
    logic [3:0]  pg, gg;
    logic [4:0]  gc;
    assign p = operand1 ^ operand2;
    assign g = operand1 & operand2;
    // Each group derives its internal carries from its own carry-in only.
    for (genvar k = 0; k < 4; k++) begin : grp
        localparam int b = 4 * k;
        assign c[b]   = gc[k];
        assign c[b+1] = g[b] | (p[b] & gc[k]);
        assign c[b+2] = g[b+1] | (p[b+1] & g[b]) | (p[b+1] & p[b] & gc[k]);
        assign c[b+3] = g[b+2] | (p[b+2] & g[b+1]) | (p[b+2] & p[b+1] & g[b])
                      | (p[b+2] & p[b+1] & p[b] & gc[k]);
        assign pg[k]  = &p[b+3:b];
        assign gg[k]  = g[b+3] | (p[b+3] & g[b+2]) | (p[b+3] & p[b+2] & g[b+1])
                      | (p[b+3] & p[b+2] & p[b+1] & g[b]);
    end
    assign gc[0] = cin;
    assign gc[1] = gg[0] | (pg[0] & cin);
    assign gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
    assign gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) | (pg[2] & pg[1] & pg[0] & cin);
    assign gc[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) | (pg[3] & pg[2] & pg[1] & gg[0])
                 | (&pg & cin);
    assign s = p ^ c;
    always_ff @(posedge clk) begin
        result <= rst ? 16'h0000 : s;
        cout   <= rst ? 1'b0 : gc[4];
`ifdef LOOKAHEAD_OVF_EN
        ovf    <= rst ? 1'b0 : gc[4] ^ c[15];
`endif
    end
endmodule

// File: tb/tb_lookahead_adder.sv
// tb_lookahead_adder: scoreboard bench for lookahead_adder; expected sums come from a behavioural model.
module tb_lookahead_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] operand1 = '0;
    logic [15:0] operand2 = '0;
    logic        cin = 1'b0;
    logic        cout;
    logic [15:0] result;
    logic        ovf;
    int          checks = 0;
    int          failures = 0;
    typedef struct packed {
        logic [16:0] sum;
        logic        v;
    } exp_t;
    exp_t q[$];

    lookahead_adder dut (
        .clk(clk),
        .rst(rst),
        .operand1(operand1),
        .operand2(operand2),
        .cin(cin),
        .cout(cout),
        .result(result)
`ifdef LOOKAHEAD_OVF_EN
        ,
        .ovf(ovf)
`endif
    );
`ifndef LOOKAHEAD_OVF_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic step(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic r,
                        input string tag);
        exp_t        e;
        logic [16:0] s;
        operand1 = a;
        operand2 = b;
        cin      = ci;
        rst      = r;
        s        = {1'b0, a} + {1'b0, b} + {16'b0, ci};
        e.sum    = r ? 17'h0 : s;
        e.v      = r ? 1'b0 : (a[15] == b[15]) && (s[15] != a[15]);
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        checks++;
        assert ({cout, result} === e.sum)
        else begin
            failures++;
            $error("FAIL %s sum got=%h exp=%h", tag, {cout, result}, e.sum);
        end
`ifdef LOOKAHEAD_OVF_EN
        checks++;
        assert (ovf === e.v)
        else begin
            failures++;
            $error("FAIL %s ovf got=%b exp=%b", tag, ovf, e.v);
        end
`endif
    endtask

    initial begin
        step(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, "reset1");
        step(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, "reset2");
        step(16'hA0A0, 16'hA0A0, 1'b0, 1'b0, "a0a0");
        step(16'h58F4, 16'hF4F4, 1'b0, 1'b0, "58f4");
        step(16'h0F3D, 16'h0F0F, 1'b0, 1'b0, "0f3d");
        step(16'hC8CA, 16'hC8CA, 1'b0, 1'b0, "c8ca");
        step(16'hFFFF, 16'h0000, 1'b1, 1'b0, "prop_all");
        step(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "max");
        step(16'h0000, 16'h0000, 1'b0, 1'b0, "zero");
        step(16'h00FF, 16'h0001, 1'b0, 1'b0, "grp_carry");
        step(16'h1234, 16'h4321, 1'b1, 1'b1, "mid_reset");
        step(16'h1111, 16'h2222, 1'b1, 1'b0, "after_reset");
        step(16'h7FFF, 16'h0001, 1'b0, 1'b0, "ovf_pos");
        step(16'h8000, 16'h8000, 1'b0, 1'b0, "ovf_neg");
        step(16'h0001, 16'h0001, 1'b0, 1'b0, "no_ovf");
        step(16'h0FFF, 16'hF000, 1'b1, 1'b0, "prop_cin");
        for (int i = 0; i < 40; i++) begin
            step(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, "random");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
